// File: rtl/hex_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hex_seq_pkg
// Description : Shared types and the 7-segment lookup for hex_display_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package hex_seq_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } seq_state_e;

    // Blank pattern in active-high form; the decoder applies panel polarity.
    localparam logic [6:0] SEG_BLANK_AH = 7'h00;

    function automatic logic [6:0] seg_of_nibble(input logic [3:0] nibble);
        logic [6:0] seg;
        seg = 7'h00;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_display_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : hex_display_sequencer_if
// Description : Value handshake plus Avalon-MM write port of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface hex_display_sequencer_if #(
    parameter int NUM_DIGITS = 6
);
    logic                      value_valid;
    logic                      value_ready;
    logic [4*NUM_DIGITS-1:0]   value_data;
    logic [NUM_DIGITS-1:0]     blank_mask;
    logic [31:0]               avm_address;
    logic                      avm_write;
    logic [31:0]               avm_writedata;
    logic                      avm_waitrequest;
    logic                      busy;
    logic                      done;

    modport master (
        input  value_valid, value_data, blank_mask, avm_waitrequest,
        output value_ready, avm_address, avm_write, avm_writedata, busy, done
    );

    modport slave (
        output value_valid, value_data, blank_mask, avm_waitrequest,
        input  value_ready, avm_address, avm_write, avm_writedata, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/hex_seg_decoder.sv
`default_nettype none
// ============================================================================
// Module      : hex_seg_decoder
// Description : Nibble + blank to 7-segment pattern with selectable polarity.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_seg_decoder
    import hex_seq_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] w_seg_ah;

    assign w_seg_ah = blank ? SEG_BLANK_AH : seg_of_nibble(nibble);
    assign seg      = ACTIVE_LOW ? ~w_seg_ah : w_seg_ah;

endmodule
`default_nettype wire

// File: rtl/hex_display_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hex_display_sequencer
// Description : Avalon-MM master writing one decoded hex digit per PIO slave.
//               Optional HEX_SKIP_UNCHANGED_EN suppresses unchanged digits.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_display_sequencer
    import hex_seq_pkg::*;
#(
    parameter int          NUM_DIGITS  = 6,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter logic [31:0] ADDR_STRIDE = 32'h0000_0010,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    hex_display_sequencer_if.master bus
);

    localparam int                 c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(NUM_DIGITS - 1);

    seq_state_e              r_state;
    logic [c_IDX_W-1:0]      r_idx;
    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_blank;
    logic                    r_done;

    logic [3:0] w_nibble;
    logic [6:0] w_pattern;
    logic       w_in_write;
    logic       w_skip;
    logic       w_complete;
    logic       w_advance;

    assign w_nibble = r_value[4*r_idx +: 4];

    hex_seg_decoder #(
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_dec (
        .nibble (w_nibble),
        .blank  (r_blank[r_idx]),
        .seg    (w_pattern)
    );

`ifdef HEX_SKIP_UNCHANGED_EN
    logic [6:0]            r_shadow [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_shadow_vld;

    assign w_skip = r_shadow_vld[r_idx] && (r_shadow[r_idx] == w_pattern);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow_vld <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_shadow[i] <= 7'h00;
            end
        end else if (w_complete) begin
            r_shadow[r_idx]     <= w_pattern;
            r_shadow_vld[r_idx] <= 1'b1;
        end
    end
`else
    assign w_skip = 1'b0;
`endif

    // Strobe derives from state so an async reset removes it immediately.
    assign w_in_write = (r_state == WRITE);
    assign w_complete = bus.avm_write && !bus.avm_waitrequest;
    assign w_advance  = w_complete || (w_in_write && w_skip);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_value <= '0;
            r_blank <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.value_valid) begin
                        r_state <= WRITE;
                        r_idx   <= '0;
                        r_value <= bus.value_data;
                        r_blank <= bus.blank_mask;
                    end
                end
                WRITE: begin
                    if (w_advance) begin
                        if (r_idx == c_LAST) begin
                            r_state <= IDLE;
                            r_idx   <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.value_ready   = (r_state == IDLE);
    assign bus.busy          = w_in_write;
    assign bus.done          = r_done;
    assign bus.avm_write     = w_in_write && !w_skip;
    assign bus.avm_address   = BASE_ADDR + ADDR_STRIDE * 32'(r_idx);
    assign bus.avm_writedata = {25'b0, (w_in_write ? w_pattern : 7'h00)};

endmodule
`default_nettype wire

// File: tb/tb_hex_display_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_display_sequencer
// Description : Directed self-checking bench for hex_display_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_display_sequencer;

    logic clk;
    logic reset_n;
    int   vectors;
    int   errors;
    int   n_writes;

    hex_display_sequencer_if #(.NUM_DIGITS(6)) bus ();

    hex_display_sequencer #(
        .NUM_DIGITS  (6),
        .BASE_ADDR   (32'h0000_1000),
        .ADDR_STRIDE (32'h0000_0010),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.avm_write && !bus.avm_waitrequest) n_writes <= n_writes + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        check("rst_ready", 32'(bus.value_ready), 32'd1);
        check("rst_write", 32'(bus.avm_write), 32'd0);
        check("rst_addr",  bus.avm_address, 32'h1000);
        check("rst_data",  bus.avm_writedata, 32'h0);
        check("rst_busy",  32'(bus.busy), 32'd0);
        check("rst_done",  32'(bus.done), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic accept(input logic [23:0] val, input logic [5:0] mask);
        bus.value_valid = 1'b1;
        bus.value_data  = val;
        bus.blank_mask  = mask;
        tick();
        bus.value_valid = 1'b0;
    endtask

    // Called at T+1; walks all six digits and returns at the done cycle.
    task automatic walk(input logic [41:0] exp, input int stall_digit,
                        input int stall_n, input bit poke);
        int          start;
        int          waits;
        logic [31:0] addr;
        start = n_writes;
        for (int d = 0; d < 6; d++) begin
            addr  = 32'h1000 + 32'(d) * 32'h10;
            waits = (d == stall_digit) ? stall_n : 0;
            for (int w = 0; w <= waits; w++) begin
                bus.avm_waitrequest = (w < waits);
                if (poke && d == 1 && w == 0) begin
                    bus.value_valid = 1'b1;
                    bus.value_data  = 24'hFFFFFF;
                end
                check("write",  32'(bus.avm_write), 32'd1);
                check("addr",   bus.avm_address, addr);
                check("data",   bus.avm_writedata, {25'b0, exp[7*d +: 7]});
                check("busy",   32'(bus.busy), 32'd1);
                check("ready",  32'(bus.value_ready), 32'd0);
                check("done_early", 32'(bus.done), 32'd0);
                tick();
                if (poke && d == 1 && w == 0) bus.value_valid = 1'b0;
            end
        end
        bus.avm_waitrequest = 1'b0;
        check("done",       32'(bus.done), 32'd1);
        check("busy_end",   32'(bus.busy), 32'd0);
        check("ready_end",  32'(bus.value_ready), 32'd1);
        check("write_end",  32'(bus.avm_write), 32'd0);
        check("n_complete", 32'(n_writes - start), 32'd6);
    endtask

    initial begin
        vectors             = 0;
        errors              = 0;
        n_writes            = 0;
        reset_n             = 1'b0;
        bus.value_valid     = 1'b0;
        bus.value_data      = '0;
        bus.blank_mask      = '0;
        bus.avm_waitrequest = 1'b0;
        tick();
        do_reset();

        // Basic sequence: 123456 -> 02 12 19 30 24 79
        accept(24'h123456, 6'b000000);
        walk({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, -1, 0, 1'b0);
        tick();
        check("done_pulse", 32'(bus.done), 32'd0);

        // Three stall cycles on digit 2, done lands at T+10
        do_reset();
        accept(24'h123456, 6'b000000);
        walk({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 2, 3, 1'b0);
        tick();

        // Digit 0 shows 8 (all lit), others blanked
        do_reset();
        accept(24'h000008, 6'b111110);
        walk({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h00}, -1, 0, 1'b0);
        tick();

        // Request offered while busy must be dropped
        do_reset();
        accept(24'h654321, 6'b000000);
        walk({7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79}, -1, 0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("no_extra_write", 32'(bus.avm_write), 32'd0);
            check("no_extra_busy",  32'(bus.busy), 32'd0);
        end

        // Reset in the middle of the write to 0x1030
        do_reset();
        accept(24'h123456, 6'b000000);
        tick();
        tick();
        tick();
        check("mid_addr", bus.avm_address, 32'h1030);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_write", 32'(bus.avm_write), 32'd0);
        check("mid_rst_busy",  32'(bus.busy), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(bus.value_ready), 32'd1);
        check("post_rst_write", 32'(bus.avm_write), 32'd0);
        check("post_rst_addr",  bus.avm_address, 32'h1000);
        tick();
        check("no_resume", 32'(bus.avm_write), 32'd0);

        // Back-to-back: valid held, second accept on the done cycle
        do_reset();
        bus.value_valid = 1'b1;
        bus.value_data  = 24'h123456;
        bus.blank_mask  = 6'b000000;
        tick();
        bus.value_data  = 24'h654321;
        walk({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, -1, 0, 1'b0);
        tick();
        bus.value_valid = 1'b0;
        walk({7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79}, -1, 0, 1'b0);
        tick();

`ifdef HEX_SKIP_UNCHANGED_EN
        begin
            int start;
            do_reset();
            // ABCDEF -> 0E 06 21 46 03 08
            accept(24'hABCDEF, 6'b000000);
            walk({7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}, -1, 0, 1'b0);
            tick();
            start = n_writes;
            accept(24'hABCDE0, 6'b000000);
            check("skip_write0", 32'(bus.avm_write), 32'd1);
            check("skip_addr0",  bus.avm_address, 32'h1000);
            check("skip_data0",  bus.avm_writedata, 32'h40);
            tick();
            for (int k = 0; k < 5; k++) begin
                check("skip_nowrite", 32'(bus.avm_write), 32'd0);
                check("skip_busy",    32'(bus.busy), 32'd1);
                tick();
            end
            check("skip_done",   32'(bus.done), 32'd1);
            check("skip_writes", 32'(n_writes - start), 32'd1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
